// File: rtl/silife_sched_pkg.sv
// silife_sched_pkg -- state and arbitration encodings shared by the display scheduler.
// Revision 1.0
`default_nettype none

package silife_sched_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INIT = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SCAN = 3'd3;
  localparam logic [2:0] ST_STEP = 3'd4;

  localparam logic LS_STEP = 1'b0;
  localparam logic LS_DISP = 1'b1;

  // Phases that depend on the external driver finishing and so run under the watchdog.
  function automatic logic watchdog_phase(input logic [2:0] st);
    return (st == ST_INIT) || (st == ST_SCAN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/silife_frame_timer.sv
// silife_frame_timer -- loadable down-counter that saturates at zero and flags expiry.
// Revision 1.0
`default_nettype none

module silife_frame_timer #(
  parameter int PERIOD_BITS = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic [PERIOD_BITS-1:0] i_load_val,
  input  logic                   i_dec,
  output logic                   o_expired
);

  logic [PERIOD_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - PERIOD_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/silife_display_scheduler.sv
// silife_display_scheduler -- arbitrates grid access between MAX7219 frame scans and life steps.
// Revision 1.0
`default_nettype none

module silife_display_scheduler
  import silife_sched_pkg::*;
#(
  parameter int PERIOD_BITS = 24,
  parameter int WATCHDOG    = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [PERIOD_BITS-1:0] i_frame_period,
  input  logic                   i_disp_busy,
  input  logic                   i_step_req,
  input  logic                   i_step_done,
  output logic                   o_disp_enable,
  output logic                   o_frame,
  output logic                   o_step_grant,
  output logic [7:0]             o_frame_count,
  output logic                   o_timeout
);

  localparam int                 WD_BITS = $clog2(WATCHDOG + 1);
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(WATCHDOG - 1);

  logic [2:0]         state_q, state_d;
  logic [WD_BITS-1:0] wd_q, wd_d;
  logic               seen_q, seen_d;
  logic [7:0]         count_q, count_d;
  logic               timeout_q, timeout_d;
  logic               den_q, den_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;

  logic timer_load;
  logic timer_dec;
  logic timer_expired;

  assign timer_dec = (state_q == ST_WAIT) || (state_q == ST_STEP);

  silife_frame_timer #(
    .PERIOD_BITS(PERIOD_BITS)
  ) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (timer_load),
    .i_load_val (i_frame_period),
    .i_dec      (timer_dec),
    .o_expired  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    seen_d     = seen_q;
    count_d    = count_q;
    timeout_d  = timeout_q;
    den_d      = den_q;
    last_d     = last_q;
    timer_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_step_req) begin
          state_d = ST_STEP;
        end else if (i_enable) begin
          state_d = ST_INIT;
          den_d   = 1'b1;
        end
      end
      ST_INIT, ST_SCAN: begin
        // Completion within the limit wins over the watchdog firing on the same cycle.
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (seen_q && !i_disp_busy) begin
          state_d    = ST_WAIT;
          timer_load = 1'b1;
          count_d    = count_q + 8'd1;
          if (state_q == ST_SCAN) begin
            last_d = LS_DISP;
          end
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (i_disp_busy) begin
          seen_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (timer_expired && !(i_step_req && (last_q == LS_DISP))) begin
          state_d = ST_SCAN;
        end else if (i_step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        // A step taken straight from IDLE never initialised the driver, so it returns there.
        if (i_step_done) begin
          last_d  = LS_STEP;
          state_d = (i_enable && den_q) ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) begin
      den_d = 1'b0;
    end
    if (state_d != state_q) begin
      seen_d = 1'b0;
    end
    wd_d    = ((state_d == state_q) && watchdog_phase(state_q)) ? wd_q + WD_BITS'(1) : '0;
    grant_d = (state_d == ST_STEP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wd_q      <= '0;
      seen_q    <= 1'b0;
      count_q   <= '0;
      timeout_q <= 1'b0;
      den_q     <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= LS_STEP;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      seen_q    <= seen_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      den_q     <= den_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

  assign o_disp_enable = den_q;
  assign o_frame       = (state_q == ST_SCAN) && !seen_q;
  assign o_step_grant  = grant_q;
  assign o_frame_count = count_q;
  assign o_timeout     = timeout_q;

endmodule

`default_nettype wire
